// File: rtl/counter_pkg.sv
// Shared encodings for the parametrised up/down counter: operating modes
// and the two-state count/halt controller.
package counter_pkg;

    // Counting mode as presented on the mode port; the reserved code is
    // handled like MODE_WRAP by the counter.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    // Controller state: ST_HALT freezes the count once a one-shot run
    // has reached its terminal value.
    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_HALT  = 1'b1
    } state_e;

endpackage : counter_pkg

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with synchronous load/clear, wrap, saturate
// and one-shot modes, a one-cycle terminal-count pulse and a sticky wrap flag.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_VAL   = (1 << WIDTH) - 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             wrapped,
    output logic             halted
);

    localparam logic [WIDTH-1:0] MAX_C   = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_C = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_C};
    localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             wrapped_q, wrapped_d;
    state_e           state_q, state_d;

    mode_e            mode_s;
    logic             wrap_mode;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH-1:0] step_val;

    // Decode mode, terminal value and the candidate next values.
    always_comb begin
        mode_s       = mode_e'(mode);
        wrap_mode    = (mode_s == MODE_WRAP) || (mode_s == MODE_RSVD);
        // The terminal follows the direction sampled this cycle, so a
        // direction flip re-targets the terminal on the same edge.
        terminal     = up_down ? MAX_C : '0;
        load_clamped = (load_val > MAX_C) ? MAX_C : load_val;
        // One spare bit keeps the step free of overflow; it is only taken
        // from a non-terminal value, so the clamp never fires in practice.
        step_ext     = up_down ? ({1'b0, count_q} + ONE_EXT)
                               : ({1'b0, count_q} - ONE_EXT);
        step_val     = (step_ext > MAX_EXT) ? MAX_C : step_ext[WIDTH-1:0];
    end

    // Next-state logic: clear > load > step > hold.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        count_d   = count_q;
        tc_d      = 1'b0;
        wrapped_d = wrapped_q;
        state_d   = state_q;

        if (clear) begin
            count_d   = RESET_C;
            wrapped_d = 1'b0;
            state_d   = ST_COUNT;
        end else if (load) begin
            count_d = load_clamped;
            state_d = ST_COUNT;
        end else if (state_q == ST_HALT) begin
            // Frozen: enable ignored; leaving one-shot mode releases the halt.
            if (mode_s != MODE_ONESHOT) begin
                state_d = ST_COUNT;
            end
        end else if (enable) begin
            if (count_q == terminal) begin
                // From the terminal only WRAP moves; the opposite end can
                // never be the terminal of the current direction, so no tc.
                if (wrap_mode) begin
                    count_d   = up_down ? '0 : MAX_C;
                    wrapped_d = 1'b1;
                end
            end else begin
                count_d = step_val;
                if (step_val == terminal) begin
                    tc_d = 1'b1;
                    if (mode_s == MODE_ONESHOT) begin
                        state_d = ST_HALT;
                    end
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= RESET_C;
            tc_q      <= 1'b0;
            wrapped_q <= 1'b0;
            state_q   <= ST_COUNT;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values, independent of statement order.
            count_q   <= count_d;
            tc_q      <= tc_d;
            wrapped_q <= wrapped_d;
            state_q   <= state_d;
        end
    end

    assign count_out = count_q;
    assign tc        = tc_q;
    assign wrapped   = wrapped_q;
    assign halted    = (state_q == ST_HALT);

endmodule : param_updown_counter
